// File: rtl/multicycle_controller.sv
// Control unit for the multicycle ARM core: main FSM, ALU decoder, condition check and NZCV flags.
// Drives every mux select and write enable of the multicycle datapath from the latched Instr[31:12].
module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_t;

    state_t      state, state_next;
    logic [3:0]  flags;
    logic        condexreg;
    logic        condex;
    logic [1:0]  flagw;
    logic [1:0]  alu_dec;
    logic        pcwrite_raw, memwrite_raw, regwrite_raw, irwrite_raw;

    // Instr carries bits [31:12] of the instruction, so field positions are offset by 12.
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [3:0]  cmd;
    logic        sbit;
    logic        rd_is_pc;
    logic        in_exec;
    logic        unused_rn;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign cmd       = funct[4:1];
    assign sbit      = funct[0];
    assign rd_is_pc  = (rd == 4'b1111);
    assign in_exec   = (state == S_EXECR) || (state == S_EXECI);
    assign unused_rn = ^Instr[7:4];

    assign flagw[1] = sbit;
    assign flagw[0] = sbit && ((cmd == 4'b0100) || (cmd == 4'b0010));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_FETCH;
            flags     <= 4'b0000;
            condexreg <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_DECODE)
                condexreg <= condex;
            // Flags change only after the instruction's own condition was latched in DECODE.
            if (in_exec && condexreg) begin
                if (flagw[1]) flags[3:2] <= ALUFlags[3:2];
                if (flagw[0]) flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Flags are {N,Z,C,V}.
    always_comb begin
        condex = 1'b0;
        unique case (cond)
            4'b0000: condex = flags[2];
            4'b0001: condex = !flags[2];
            4'b0010: condex = flags[1];
            4'b0011: condex = !flags[1];
            4'b0100: condex = flags[3];
            4'b0101: condex = !flags[3];
            4'b0110: condex = flags[0];
            4'b0111: condex = !flags[0];
            4'b1000: condex = flags[1] && !flags[2];
            4'b1001: condex = !flags[1] || flags[2];
            4'b1010: condex = (flags[3] == flags[0]);
            4'b1011: condex = (flags[3] != flags[0]);
            4'b1100: condex = !flags[2] && (flags[3] == flags[0]);
            4'b1101: condex = flags[2] || (flags[3] != flags[0]);
            4'b1110: condex = 1'b1;
            4'b1111: condex = 1'b0;
        endcase
    end

    always_comb begin
        unique case (cmd)
            4'b0100: alu_dec = 2'b00;
            4'b0010: alu_dec = 2'b01;
            4'b0000: alu_dec = 2'b10;
            4'b1100: alu_dec = 2'b11;
            default: alu_dec = 2'b00;
        endcase
    end

    // NOTE: every output gets a default before the case, so no state leaves a latch behind.
    always_comb begin
        state_next   = S_FETCH;
        pcwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        regwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        AdrSrc       = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ResultSrc    = 2'b00;
        ALUControl   = 2'b00;
        unique case (state)
            S_FETCH: begin
                state_next  = S_DECODE;
                irwrite_raw = 1'b1;
                pcwrite_raw = 1'b1;
                ALUSrcA     = 1'b1;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                unique case (op)
                    2'b00:   state_next = funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_next = S_MEMADR;
                    2'b10:   state_next = S_BRANCH;
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                state_next = funct[0] ? S_MEMRD : S_MEMWR;
                ALUSrcB    = 2'b01;
            end
            S_MEMRD: begin
                state_next = S_MEMWB;
                AdrSrc     = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc       = 1'b1;
                memwrite_raw = condexreg;
            end
            S_MEMWB: begin
                ResultSrc    = 2'b01;
                regwrite_raw = condexreg;
                pcwrite_raw  = condexreg && rd_is_pc;
            end
            S_EXECR: begin
                state_next = S_ALUWB;
                ALUControl = alu_dec;
            end
            S_EXECI: begin
                state_next = S_ALUWB;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
            end
            S_ALUWB: begin
                regwrite_raw = condexreg;
                pcwrite_raw  = condexreg && rd_is_pc;
            end
            S_BRANCH: begin
                ALUSrcB     = 2'b01;
                ResultSrc   = 2'b10;
                pcwrite_raw = condexreg;
            end
            default: state_next = S_FETCH;
        endcase
    end

    assign RegSrc = {op == 2'b01, op == 2'b10};
    assign ImmSrc = op;

    // Reset is asynchronous, so enables are gated directly rather than waiting for the state to clear.
    assign PCWrite  = pcwrite_raw  && reset;
    assign MemWrite = memwrite_raw && reset;
    assign RegWrite = regwrite_raw && reset;
    assign IRWrite  = irwrite_raw  && reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: a per-instruction reference model pushes expected
// control vectors for each cycle; a negedge monitor pops and compares them against the DUT.
module tb_multicycle_controller;

    logic        clk;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0]  RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

    multicycle_controller dut (
        .clk       (clk),
        .reset     (reset),
        .Instr     (Instr),
        .ALUFlags  (ALUFlags),
        .PCWrite   (PCWrite),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .RegSrc    (RegSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ImmSrc    (ImmSrc),
        .ALUControl(ALUControl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw;
        logic       mw;
        logic       rw;
        logic       irw;
        logic       adr;
        logic [1:0] regsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic [1:0] immsrc;
        logic [1:0] aluctl;
    } ctl_t;

    ctl_t        exp_q[$];
    string       name_q[$];
    ctl_t        model_v[5];
    logic [3:0]  mflags;
    int          n_checks;
    int          n_fail;

    task automatic check(input string name, input ctl_t act, input ctl_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got pcw%b mw%b rw%b irw%b adr%b rs%b sa%b sb%b res%b imm%b alu%b, expected pcw%b mw%b rw%b irw%b adr%b rs%b sa%b sb%b res%b imm%b alu%b",
                     name, act.pcw, act.mw, act.rw, act.irw, act.adr, act.regsrc, act.alusrca,
                     act.alusrcb, act.resultsrc, act.immsrc, act.aluctl,
                     exp.pcw, exp.mw, exp.rw, exp.irw, exp.adr, exp.regsrc, exp.alusrca,
                     exp.alusrcb, exp.resultsrc, exp.immsrc, exp.aluctl);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ctl_t  e;
            ctl_t  a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
                  ALUSrcB, ResultSrc, ImmSrc, ALUControl};
            check(nm, a, e);
        end
    end

    // ARM conditions as a base test on cond[3:1] with cond[0] inverting it.
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: return !c[0];
        endcase
        return base ^ c[0];
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] cmd);
        if (cmd == 4'd4)  return 2'b00;
        if (cmd == 4'd2)  return 2'b01;
        if (cmd == 4'd0)  return 2'b10;
        if (cmd == 4'd12) return 2'b11;
        return 2'b00;
    endfunction

    function automatic ctl_t base_of(input logic [19:0] ins);
        ctl_t b;
        b        = '0;
        b.regsrc = {ins[15:14] == 2'b01, ins[15:14] == 2'b10};
        b.immsrc = ins[15:14];
        return b;
    endfunction

    function automatic ctl_t fetch_like(input logic [19:0] ins);
        ctl_t b;
        b           = base_of(ins);
        b.alusrca   = 1'b1;
        b.alusrcb   = 2'b10;
        b.resultsrc = 2'b10;
        return b;
    endfunction

    // Expected per-cycle vectors for one instruction plus the flags it leaves behind.
    task automatic build(input logic [19:0] ins, input logic [3:0] af,
                         output int len, output logic [3:0] nf);
        logic [1:0] op;
        logic [5:0] funct;
        logic       cex, to_pc;
        ctl_t       b;
        op    = ins[15:14];
        funct = ins[13:8];
        b     = base_of(ins);
        cex   = cond_ok(ins[19:16], mflags);
        to_pc = (ins[3:0] == 4'hF);
        nf    = mflags;
        for (int i = 0; i < 5; i++) model_v[i] = b;
        model_v[0]     = fetch_like(ins);
        model_v[0].irw = 1'b1;
        model_v[0].pcw = 1'b1;
        model_v[1]     = fetch_like(ins);
        if (op == 2'b11) begin
            len = 2;
        end else if (op == 2'b00) begin
            len                = 4;
            model_v[2].alusrcb = funct[5] ? 2'b01 : 2'b00;
            model_v[2].aluctl  = alu_of(funct[4:1]);
            model_v[3].rw      = cex;
            model_v[3].pcw     = cex && to_pc;
            if (cex && funct[0]) begin
                nf[3:2] = af[3:2];
                if (funct[4:1] == 4'd4 || funct[4:1] == 4'd2) nf[1:0] = af[1:0];
            end
        end else if (op == 2'b01) begin
            model_v[2].alusrcb = 2'b01;
            model_v[3].adr     = 1'b1;
            if (funct[0]) begin
                len                  = 5;
                model_v[4].resultsrc = 2'b01;
                model_v[4].rw        = cex;
                model_v[4].pcw       = cex && to_pc;
            end else begin
                len           = 4;
                model_v[3].mw = cex;
            end
        end else begin
            len                  = 3;
            model_v[2].alusrcb   = 2'b01;
            model_v[2].resultsrc = 2'b10;
            model_v[2].pcw       = cex;
        end
    endtask

    // Called at a drive point (just after a rising edge); returns at the next one.
    task automatic do_reset(input int cycles);
        reset  = 1'b0;
        mflags = 4'b0000;
        for (int i = 0; i < cycles; i++) begin
            exp_q.push_back(fetch_like(Instr));
            name_q.push_back($sformatf("reset %05h cyc %0d", Instr, i));
        end
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
    endtask

    task automatic run_instr(input logic [19:0] ins, input logic [3:0] af, input int abort_k);
        int         len, run;
        logic [3:0] nf;
        Instr    = ins;
        ALUFlags = af;
        build(ins, af, len, nf);
        run = (abort_k > 0 && abort_k < len) ? abort_k : len;
        for (int c = 0; c < run; c++) begin
            exp_q.push_back(model_v[c]);
            name_q.push_back($sformatf("instr %05h cyc %0d", ins, c));
        end
        if (run >= 3) mflags = nf;
        repeat (run) begin
            @(posedge clk);
            #1;
        end
        if (run < len) do_reset(2);
    endtask

    initial begin
        logic [19:0] ins;
        int          ab;
        n_checks = 0;
        n_fail   = 0;
        mflags   = 4'b0000;
        reset    = 1'b0;
        Instr    = 20'hE0812;
        ALUFlags = 4'b0000;
        @(posedge clk);
        #1;
        do_reset(3);

        run_instr(20'hE0812, 4'b1111, 0);  // ADD: flags untouched
        run_instr(20'hE5912, 4'b0000, 0);  // LDR
        run_instr(20'hE5812, 4'b0000, 0);  // STR
        run_instr(20'hE0512, 4'b0100, 0);  // SUBS -> Z=1
        run_instr(20'h0A000, 4'b0000, 0);  // BEQ taken
        run_instr(20'hE0512, 4'b0000, 0);  // SUBS -> Z=0
        run_instr(20'h0A000, 4'b0000, 0);  // BEQ not taken
        run_instr(20'hE0512, 4'b0100, 0);  // SUBS -> Z=1
        run_instr(20'h10812, 4'b0000, 0);  // ADDNE suppressed
        run_instr(20'hE081F, 4'b0000, 0);  // ADD to PC
        run_instr(20'hF081F, 4'b0000, 0);  // never-condition
        run_instr(20'hEC000, 4'b0000, 0);  // Op=11 no-op
        run_instr(20'hE0812, 4'b0000, 3);  // abandoned mid-instruction
        run_instr(20'hE5912, 4'b0000, 4);  // LDR abandoned before writeback

        for (int i = 0; i < 400; i++) begin
            ins = 20'($urandom);
            if ($urandom_range(0, 2) != 0) ins[19:16] = 4'hE;
            if ($urandom_range(0, 9) == 0) ins[3:0] = 4'hF;
            ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_instr(ins, 4'($urandom), ab);
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
